// File: rtl/sipo_frame_receiver.sv
// sipo_frame_receiver: MSB-first serial frame receiver with a one-word valid/ready holding register.
// Define SIPO_PARITY_EN to add a trailing even-parity bit and the sticky parity_err flag.
module sipo_frame_receiver #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_en,
   input  logic             serial_in,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overrun,
   input  logic             ovr_clr,
   output logic             parity_err
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
`ifdef SIPO_PARITY_EN
   typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif
   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] new_word;
   logic             last;
   logic             done;
   assign busy = state != IDLE;
   always_comb begin
      word = {shift_reg[WIDTH-2:0], serial_in};
      last = state == DATA && cnt == CW'(WIDTH - 1);
`ifdef SIPO_PARITY_EN
      done     = in_en && state == PARITY;
      new_word = shift_reg;
`else
      done     = in_en && last;
      new_word = word;
`endif
   end
`ifdef SIPO_PARITY_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) parity_err <= 1'b0;
      else      parity_err <= (done && (^shift_reg ^ serial_in)) || (parity_err && !ovr_clr);
`else
   assign parity_err = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         shift_reg <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (in_en && state == IDLE && serial_in) begin
            state <= DATA;
            cnt   <= '0;
         end
         if (in_en && state == DATA) begin
            shift_reg <= word;
            cnt       <= cnt + CW'(1);
`ifdef SIPO_PARITY_EN
            if (last) state <= PARITY;
`else
            if (last) state <= IDLE;
`endif
         end
`ifdef SIPO_PARITY_EN
         if (in_en && state == PARITY) state <= IDLE;
`endif
         // a completed word is dropped only when the held word is not leaving this edge
         if (done && (!out_valid || out_ready)) begin
            out_data  <= new_word;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         overrun <= (done && out_valid && !out_ready) || (overrun && !ovr_clr);
      end
   end
endmodule
